toggle_event_decoder: RTL and testbench

- Receive end of a toggle-encoded event line. The transmitter is a T flip-flop whose t input is pulsed once per event.
- Every level change on t_in is synchronized, detected and converted to a one-cycle evt_pulse.
- Events are queued in a pending counter that a consumer drains with evt_ack.
- Sits at clock-domain or block boundaries wherever a T-flop toggle line carries events.

---
 rtl/toggle_event_decoder.sv | 134 +++++++++++++
 tb/tb_toggle_event_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// Toggle-line event decoder: synchronizer, change detector and pending-event counter.
// Optional stability filter on the synchronized line: define TOGGLE_DEC_FILTER_EN.
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
`ifdef TOGGLE_DEC_FILTER_EN
  ,
  parameter int FILTER_LEN  = 3
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_in,
  input  logic             evt_ack,
  output logic             evt_pulse,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             level
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [2:0] FLUSH_LAST = 3'(SYNC_STAGES - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_flush;
  logic                   r_level;
  logic                   r_pulse;
  logic                   r_ovf;
  logic [CNT_W-1:0]       r_pend;

  logic w_last;
  logic w_diff;
  logic w_run;
  logic w_det;
  logic w_ack;

  assign w_last = r_sync[SYNC_STAGES-1];
  assign w_diff = w_last ^ r_level;
  assign w_run  = (r_state == ST_RUN);
  assign w_ack  = w_run & evt_ack;

`ifdef TOGGLE_DEC_FILTER_EN
  localparam logic [2:0] FILT_LAST = 3'(FILTER_LEN - 1);

  logic [2:0] r_fcnt;

  assign w_det = w_run & w_diff & (r_fcnt == FILT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fcnt <= '0;
    end else if (!w_run || !w_diff || w_det) begin
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 3'd1;
    end
  end
`else
  assign w_det = w_run & w_diff;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= '0;
      r_state <= ST_INIT;
      r_flush <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], t_in};
      r_pulse <= 1'b0;
      unique case (r_state)
        ST_INIT: begin
          // Track the value entering the last stage so RUN starts with no difference.
          r_level <= r_sync[SYNC_STAGES-2];
          if (r_flush == FLUSH_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_flush <= r_flush + 3'd1;
          end
        end
        ST_RUN: begin
          if (w_det) begin
            r_level <= w_last;
            r_pulse <= 1'b1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      unique case ({w_det, w_ack})
        2'b10: begin
          if (r_pend == PEND_MAX) begin
            r_ovf <= 1'b1;
          end else begin
            r_pend <= r_pend + 1'b1;
          end
        end
        2'b01: begin
          if (r_pend != '0) begin
            r_pend <= r_pend - 1'b1;
          end
        end
        2'b11: begin
          if (r_pend == '0) begin
            r_pend <= {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: r_pend <= r_pend;
      endcase
    end
  end

  assign evt_pulse = r_pulse;
  assign evt_valid = (r_pend != '0);
  assign pending   = r_pend;
  assign overflow  = r_ovf;
  assign level     = r_level;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: sample-history reference model feeding a pulse scoreboard.
// Directed scenarios followed by a randomized run with occasional resets.
module tb_toggle_event_decoder;

  localparam int SS = 2;
  localparam int CW = 4;
`ifdef TOGGLE_DEC_FILTER_EN
  localparam int F = 3;
`else
  localparam int F = 1;
`endif
  localparam int LAT  = SS + F - 1;
  localparam int PMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          t_in;
  logic          evt_ack;
  logic          evt_pulse;
  logic          evt_valid;
  logic [CW-1:0] pending;
  logic          overflow;
  logic          level;

  typedef struct {
    int cyc;
    int pend;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   m_R      = -1;
  int   m_pend   = 0;
  bit   m_ovf    = 1'b0;
  bit   m_level  = 1'b0;
  bit   started  = 1'b0;
  bit   samp[int];
  bit   tv;

  always #5 clk = ~clk;

  toggle_event_decoder #(
    .SYNC_STAGES(SS),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .t_in     (t_in),
    .evt_ack  (evt_ack),
    .evt_pulse(evt_pulse),
    .evt_valid(evt_valid),
    .pending  (pending),
    .overflow (overflow),
    .level    (level)
  );

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: an event is a change in the sampled t_in after the first
  // post-reset sample, reported SS edges later once held F samples.
  always @(posedge clk) begin : model
    bit det;
    bit win;
    bit run;
    bit ack;
    int idx;
    cyc++;
    if (reset !== 1'b1) begin
      started = 1'b1;
      m_R     = -1;
      m_pend  = 0;
      m_ovf   = 1'b0;
      m_level = 1'b0;
      exp_q.delete();
    end else if (started) begin
      samp[cyc] = t_in;
      if (m_R < 0) begin
        m_R     = cyc;
        m_level = t_in;
      end
      run = (cyc >= m_R + SS);
      det = 1'b0;
      if (run) begin
        win = 1'b1;
        for (int k = 0; k < F; k++) begin
          idx = cyc - SS - k;
          if (idx <= m_R || samp[idx] == m_level) win = 1'b0;
        end
        det = win;
      end
      if (det) m_level = ~m_level;
      ack = run && (evt_ack === 1'b1);
      if (det && !ack) begin
        if (m_pend == PMAX) m_ovf = 1'b1;
        else m_pend++;
      end else if (ack && !det) begin
        if (m_pend > 0) m_pend--;
      end else if (det && ack && m_pend == 0) begin
        m_pend = 1;
      end
      if (det) exp_q.push_back('{cyc: cyc, pend: m_pend, ovf: int'(m_ovf)});
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (started) begin
      if (evt_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("sb_spurious_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pulse_cycle", cyc, e.cyc);
          chk("sb_pulse_pending", int'(pending), e.pend);
          chk("sb_pulse_overflow", int'(overflow), e.ovf);
        end
      end
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("sb_missed_pulse_at", cyc, e.cyc);
      end
      chk("pending", int'(pending), m_pend);
      chk("evt_valid", int'(evt_valid), int'(m_pend != 0));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (m_R < 0) chk("level_reset", int'(level), 0);
      else if (cyc >= m_R + SS - 1) chk("level", int'(level), int'(m_level));
    end
  end

  task automatic drive(input bit r, input bit t, input bit a);
    reset   = r;
    t_in    = t;
    evt_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_n(input int n);
    for (int i = 0; i < n; i++) begin
      tv = ~tv;
      repeat (F) drive(1'b1, tv, 1'b0);
    end
  endtask

  initial begin
    reset   = 1'b0;
    t_in    = 1'b1;
    evt_ack = 1'b0;
    tv      = 1'b1;

    // 1: t_in high through reset release
    repeat (3) drive(1'b0, tv, 1'b0);
    repeat (SS + 6) drive(1'b1, tv, 1'b0);
    chk("t1_level", int'(level), 1);
    chk("t1_pending", int'(pending), 0);
    chk("t1_valid", int'(evt_valid), 0);

    // 2: single toggle latency and ack
    tv = ~tv;
    drive(1'b1, tv, 1'b0);
    repeat (LAT - 1) drive(1'b1, tv, 1'b0);
    chk("t2_no_early_pulse", int'(evt_pulse), 0);
    drive(1'b1, tv, 1'b0);
    chk("t2_pulse", int'(evt_pulse), 1);
    chk("t2_pending", int'(pending), 1);
    chk("t2_valid", int'(evt_valid), 1);
    drive(1'b1, tv, 1'b0);
    chk("t2_pulse_one_cycle", int'(evt_pulse), 0);
    drive(1'b1, tv, 1'b1);
    chk("t2_acked", int'(pending), 0);

    // 3: burst of five, drain, extra ack
    toggle_n(5);
    repeat (LAT + 1) drive(1'b1, tv, 1'b0);
    chk("t3_pending5", int'(pending), 5);
    repeat (5) drive(1'b1, tv, 1'b1);
    chk("t3_drained", int'(pending), 0);
    drive(1'b1, tv, 1'b1);
    chk("t3_no_underflow", int'(pending), 0);
    chk("t3_valid", int'(evt_valid), 0);

    // 4: saturation
    repeat (2) drive(1'b0, tv, 1'b0);
    repeat (SS + 2) drive(1'b1, tv, 1'b0);
    toggle_n(16);
    repeat (LAT + 1) drive(1'b1, tv, 1'b0);
    chk("t4_pending_sat", int'(pending), PMAX);
    chk("t4_overflow", int'(overflow), 1);
    drive(1'b1, tv, 1'b1);
    chk("t4_after_ack", int'(pending), PMAX - 1);
    chk("t4_overflow_sticky", int'(overflow), 1);

    // 5: detect coincident with ack, then reset mid-run
    repeat (2) drive(1'b0, tv, 1'b0);
    repeat (SS + 2) drive(1'b1, tv, 1'b0);
    toggle_n(3);
    repeat (LAT + 1) drive(1'b1, tv, 1'b0);
    chk("t5_pending3", int'(pending), 3);
    tv = ~tv;
    drive(1'b1, tv, 1'b0);
    repeat (LAT - 1) drive(1'b1, tv, 1'b0);
    drive(1'b1, tv, 1'b1);
    chk("t5_pulse_with_ack", int'(evt_pulse), 1);
    chk("t5_pending_hold", int'(pending), 3);
    drive(1'b0, tv, 1'b0);
    chk("t5_reset_pending", int'(pending), 0);
    chk("t5_reset_overflow", int'(overflow), 0);
    chk("t5_reset_pulse", int'(evt_pulse), 0);
    repeat (SS + 3) drive(1'b1, tv, 1'b1);
    chk("t5_reinit_pending", int'(pending), 0);

`ifdef TOGGLE_DEC_FILTER_EN
    // 6: glitch rejection and filtered acceptance
    repeat (2) drive(1'b1, ~tv, 1'b0);
    repeat (LAT + 3) drive(1'b1, tv, 1'b0);
    chk("t6_glitch_ignored", int'(pending), 0);
    tv = ~tv;
    repeat (LAT + 1) drive(1'b1, tv, 1'b0);
    chk("t6_filtered_event", int'(pending), 1);
`endif

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit a;
      r = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 2) == 0) tv = ~tv;
      if (((i / 500) % 2) == 1) a = ($urandom_range(0, 1) == 0);
      else a = ($urandom_range(0, 7) == 0);
      drive(r, tv, a);
    end

    repeat (LAT + 3) drive(1'b1, tv, 1'b0);
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
